// File: rtl/serv_pc_seq.sv
// Fetch/decode/execute sequencer and cycle counter for the serial PC datapath.
// Define SERV_PC_SEQ_MISALIGN_EN to add misaligned-jump detection and a trap pass.
module serv_pc_seq #(
    parameter int W      = 1,
    parameter int WITH_C = 0
) (
    input  logic         clk,
    input  logic         i_rst,
    output logic         o_ibus_cyc,
    input  logic         i_ibus_ack,
    input  logic         i_rf_ready,
    input  logic         i_jump,
    input  logic [W-1:0] i_bad_pc,
    output logic         o_pc_en,
    output logic         o_cnt0,
    output logic         o_cnt1,
    output logic         o_cnt2,
    output logic         o_cnt03,
    output logic         o_cnt12to31,
    output logic         o_cnt_done,
    output logic         o_trap
);

    localparam int CW = (W == 1) ? 5 : 3;
    localparam logic [CW-1:0] LAST = CW'(32 / W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] TRAP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ibus_cyc_q, ibus_cyc_d;
    logic          trap_q, trap_d;
    logic          active;
    logic          last;
    logic          unused_ok;

    assign active = (state_q == RUN) || (state_q == TRAP);
    assign last   = active && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (i_ibus_ack) state_d = DECODE;
            DECODE:  if (i_rf_ready) state_d = RUN;
            RUN:     if (last) state_d = trap_q ? TRAP : FETCH;
            TRAP:    if (last) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Counter runs only while a pass is in progress and wraps on its last beat.
    assign cnt_d      = (active && !last) ? cnt_q + CW'(1) : '0;
    assign ibus_cyc_d = (state_d == FETCH);

`ifdef SERV_PC_SEQ_MISALIGN_EN
    logic bad_bit;
    logic misalign;

    // Target bit 1 arrives on lane 0 at beat 1 (W=1) or lane 1 at beat 0 (W=4).
    assign bad_bit  = (W == 1) ? (i_bad_pc[0] && (cnt_q == CW'(1)))
                               : (i_bad_pc[(W > 1) ? 1 : 0] && (cnt_q == '0));
    assign misalign = (WITH_C == 0) && (state_q == RUN) && i_jump && bad_bit;
    assign trap_d   = ((state_q == RUN) && (state_d == TRAP)) ? 1'b0
                                                              : (trap_q || misalign);
`else
    assign trap_d = 1'b0;
`endif

    assign unused_ok = ^{i_jump, i_bad_pc, WITH_C[0]};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ibus_cyc_q <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ibus_cyc_q <= ibus_cyc_d;
            trap_q     <= trap_d;
        end
    end

    assign o_ibus_cyc = ibus_cyc_q;
    assign o_pc_en    = active;
    assign o_cnt_done = last;
    assign o_trap     = (state_q == TRAP);

    if (W == 1) begin : g_w1
        assign o_cnt0      = active && (cnt_q == '0);
        assign o_cnt1      = active && (cnt_q == CW'(1));
        assign o_cnt2      = active && (cnt_q == CW'(2));
        assign o_cnt03     = 1'b0;
        assign o_cnt12to31 = active && (cnt_q >= CW'(12));
    end else begin : g_w4
        assign o_cnt0      = active && (cnt_q == '0);
        assign o_cnt1      = 1'b0;
        assign o_cnt2      = 1'b0;
        assign o_cnt03     = active && (cnt_q == '0);
        assign o_cnt12to31 = active && (cnt_q >= CW'(3));
    end

endmodule
